// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read address/data channel pair between the
// instruction-fetch and load requesters, with one single-beat transaction in flight.
module axi_rd_arbiter #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] if_addr_i,
  output logic                      if_ready_o,
  output logic [AXI_DATA_WIDTH-1:0] if_data_o,
  input  logic                      mem_valid_i,
  input  logic [AXI_ADDR_WIDTH-1:0] mem_addr_i,
  output logic                      mem_ready_o,
  output logic [AXI_DATA_WIDTH-1:0] mem_data_o,
  output logic                      rd_err_o,
  output logic [AXI_ID_WIDTH-1:0]   axi_ar_id_o,
  output logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o,
  output logic                      axi_ar_valid_o,
  input  logic                      axi_ar_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]   axi_r_id_i,
  input  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i,
  input  logic [1:0]                axi_r_resp_i,
  input  logic                      axi_r_valid_i,
  output logic                      axi_r_ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_e;

  localparam logic [AXI_ID_WIDTH-1:0] ID_IF  = '0;
  localparam logic [AXI_ID_WIDTH-1:0] ID_MEM = AXI_ID_WIDTH'(1);

  state_e                    state_q, state_d;
  logic                      gnt_mem_q, gnt_mem_d;   // 1: MEM owns the transaction
  logic                      last_mem_q, last_mem_d; // 1: MEM was granted last
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
  logic [AXI_ID_WIDTH-1:0]   ar_id_q, ar_id_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      r_ready_q, r_ready_d;
  logic [AXI_DATA_WIDTH-1:0] if_data_q, if_data_d;
  logic [AXI_DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                      if_ready_q, if_ready_d;
  logic                      mem_ready_q, mem_ready_d;
  logic                      err_q, err_d;
  logic                      pick_mem;
  logic                      beat_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_mem_q   <= 1'b0;
      last_mem_q  <= 1'b0;
      ar_addr_q   <= '0;
      ar_id_q     <= '0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      if_data_q   <= '0;
      mem_data_q  <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      gnt_mem_q   <= gnt_mem_d;
      last_mem_q  <= last_mem_d;
      ar_addr_q   <= ar_addr_d;
      ar_id_q     <= ar_id_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_mem_d   = gnt_mem_q;
    last_mem_d  = last_mem_q;
    ar_addr_d   = ar_addr_q;
    ar_id_d     = ar_id_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    err_d       = 1'b0;
    // On a tie the requester not granted last wins
    pick_mem    = mem_valid_i && (!if_valid_i || !last_mem_q);
    beat_hit    = axi_r_valid_i && (axi_r_id_i == ar_id_q);

    case (state_q)
      S_IDLE: begin
        if (if_valid_i || mem_valid_i) begin
          gnt_mem_d  = pick_mem;
          last_mem_d = pick_mem;
          ar_addr_d  = pick_mem ? mem_addr_i : if_addr_i;
          ar_id_d    = pick_mem ? ID_MEM : ID_IF;
          state_d    = S_AR;
        end
      end
      S_AR: begin
        if (axi_ar_ready_i) begin
          state_d = S_R;
        end
      end
      S_R: begin
        // Beats with a foreign ID are accepted (r_ready high) and dropped
        if (beat_hit) begin
          if (gnt_mem_q) begin
            mem_data_d  = axi_r_data_i;
            mem_ready_d = 1'b1;
          end else begin
            if_data_d  = axi_r_data_i;
            if_ready_d = 1'b1;
          end
          err_d   = (axi_r_resp_i != 2'b00);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ar_valid_d = (state_d == S_AR);
    r_ready_d  = (state_d == S_R);
  end

  assign if_ready_o     = if_ready_q;
  assign if_data_o      = if_data_q;
  assign mem_ready_o    = mem_ready_q;
  assign mem_data_o     = mem_data_q;
  assign rd_err_o       = err_q;
  assign axi_ar_id_o    = ar_id_q;
  assign axi_ar_addr_o  = ar_addr_q;
  assign axi_ar_valid_o = ar_valid_q;
  assign axi_r_ready_o  = r_ready_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: drives both requesters and a scripted AXI
// slave, checking each handshake cycle against hand-computed values.
module tb_axi_rd_arbiter;

  logic        clk;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_addr_i;
  logic        if_ready_o;
  logic [63:0] if_data_o;
  logic        mem_valid_i;
  logic [31:0] mem_addr_i;
  logic        mem_ready_o;
  logic [63:0] mem_data_o;
  logic        rd_err_o;
  logic [3:0]  axi_ar_id_o;
  logic [31:0] axi_ar_addr_o;
  logic        axi_ar_valid_o;
  logic        axi_ar_ready_i;
  logic [3:0]  axi_r_id_i;
  logic [63:0] axi_r_data_i;
  logic [1:0]  axi_r_resp_i;
  logic        axi_r_valid_i;
  logic        axi_r_ready_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_if_data;
  logic [63:0] exp_mem_data;

  axi_rd_arbiter #(
    .AXI_DATA_WIDTH(64),
    .AXI_ADDR_WIDTH(32),
    .AXI_ID_WIDTH  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_valid_i    (if_valid_i),
    .if_addr_i     (if_addr_i),
    .if_ready_o    (if_ready_o),
    .if_data_o     (if_data_o),
    .mem_valid_i   (mem_valid_i),
    .mem_addr_i    (mem_addr_i),
    .mem_ready_o   (mem_ready_o),
    .mem_data_o    (mem_data_o),
    .rd_err_o      (rd_err_o),
    .axi_ar_id_o   (axi_ar_id_o),
    .axi_ar_addr_o (axi_ar_addr_o),
    .axi_ar_valid_o(axi_ar_valid_o),
    .axi_ar_ready_i(axi_ar_ready_i),
    .axi_r_id_i    (axi_r_id_i),
    .axi_r_data_i  (axi_r_data_i),
    .axi_r_resp_i  (axi_r_resp_i),
    .axi_r_valid_i (axi_r_valid_i),
    .axi_r_ready_o (axi_r_ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ar_valid"}, axi_ar_valid_o, 0);
    chk({tag, ".r_ready"},  axi_r_ready_o, 0);
    chk({tag, ".if_ready"}, if_ready_o, 0);
    chk({tag, ".mem_ready"}, mem_ready_o, 0);
    chk({tag, ".err"},      rd_err_o, 0);
    chk({tag, ".ar_addr"},  axi_ar_addr_o, 0);
    chk({tag, ".ar_id"},    axi_ar_id_o, 0);
    chk({tag, ".if_data"},  if_data_o, 0);
    chk({tag, ".mem_data"}, mem_data_o, 0);
  endtask

  // Entered in IDLE with the request(s) already driven; returns in IDLE.
  task automatic run_txn(input string tag, input logic exp_mem, input logic [31:0] exp_addr,
                         input logic [63:0] data, input logic [1:0] resp,
                         input int ar_wait, input int bad_beats, input logic keep);
    logic [3:0] exp_id;
    exp_id = exp_mem ? 4'd1 : 4'd0;
    step();
    chk({tag, ".ar_valid"}, axi_ar_valid_o, 1);
    chk({tag, ".ar_id"},    axi_ar_id_o, exp_id);
    chk({tag, ".ar_addr"},  axi_ar_addr_o, exp_addr);
    for (int i = 0; i < ar_wait; i++) begin
      step();
      chk($sformatf("%s.hold%0d", tag, i), {axi_ar_valid_o, axi_ar_id_o, axi_ar_addr_o},
          {1'b1, exp_id, exp_addr});
      chk($sformatf("%s.hold_rr%0d", tag, i), axi_r_ready_o, 0);
    end
    axi_ar_ready_i = 1'b1;
    step();
    axi_ar_ready_i = 1'b0;
    chk({tag, ".r_ready"},   axi_r_ready_o, 1);
    chk({tag, ".ar_drop"},   axi_ar_valid_o, 0);
    for (int i = 0; i < bad_beats; i++) begin
      axi_r_valid_i = 1'b1;
      axi_r_id_i    = 4'd3;
      axi_r_data_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      axi_r_resp_i  = 2'b00;
      step();
      chk($sformatf("%s.bad_rr%0d", tag, i), axi_r_ready_o, 1);
      chk($sformatf("%s.bad_rdy%0d", tag, i), {if_ready_o, mem_ready_o}, 0);
    end
    axi_r_valid_i = 1'b1;
    axi_r_id_i    = exp_id;
    axi_r_data_i  = data;
    axi_r_resp_i  = resp;
    step();
    axi_r_valid_i = 1'b0;
    axi_r_resp_i  = 2'b00;
    if (exp_mem) exp_mem_data = data;
    else         exp_if_data  = data;
    chk({tag, ".if_ready"},  if_ready_o, !exp_mem);
    chk({tag, ".mem_ready"}, mem_ready_o, exp_mem);
    chk({tag, ".err"},       rd_err_o, resp != 2'b00);
    chk({tag, ".if_data"},   if_data_o, exp_if_data);
    chk({tag, ".mem_data"},  mem_data_o, exp_mem_data);
    chk({tag, ".r_ready_done"}, axi_r_ready_o, 0);
    if (!keep) begin
      if (exp_mem) mem_valid_i = 1'b0;
      else         if_valid_i  = 1'b0;
    end
    step();
    chk({tag, ".rdy_clear"}, {if_ready_o, mem_ready_o, rd_err_o}, 0);
  endtask

  initial begin
    rst = 1'b0;
    if_valid_i = 0; if_addr_i = 0; mem_valid_i = 0; mem_addr_i = 0;
    axi_ar_ready_i = 0; axi_r_id_i = 0; axi_r_data_i = 0; axi_r_resp_i = 0; axi_r_valid_i = 0;
    exp_if_data = 0; exp_mem_data = 0;
    step(); step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();

    // Single IF read, immediate slave
    if_valid_i = 1'b1; if_addr_i = 32'h8000_0000;
    run_txn("if1", 0, 32'h8000_0000, 64'h1122334455667788, 2'b00, 0, 0, 0);

    // Fresh reset, then a tie: MEM first, then alternation
    rst = 1'b0; #1; rst = 1'b1;
    exp_if_data = 0;
    step();
    if_valid_i = 1'b1;  if_addr_i  = 32'h0000_1000;
    mem_valid_i = 1'b1; mem_addr_i = 32'h0000_2000;
    run_txn("tie1", 1, 32'h0000_2000, 64'hA1, 2'b00, 0, 0, 1);
    run_txn("tie2", 0, 32'h0000_1000, 64'hA2, 2'b00, 0, 0, 1);
    run_txn("tie3", 1, 32'h0000_2000, 64'hA3, 2'b00, 0, 0, 1);
    run_txn("tie4", 0, 32'h0000_1000, 64'hA4, 2'b00, 0, 0, 0);

    // Remaining MEM request with ar_ready withheld 5 cycles
    run_txn("arwait", 1, 32'h0000_2000, 64'hB5, 2'b00, 5, 0, 0);

    // Foreign-ID beat discarded before the matching one
    mem_valid_i = 1'b1; mem_addr_i = 32'h0000_3000;
    run_txn("badid", 1, 32'h0000_3000, 64'hDEAD, 2'b00, 0, 1, 0);

    // SLVERR on MEM, then OKAY on IF
    mem_valid_i = 1'b1; mem_addr_i = 32'h0000_4000;
    run_txn("slverr", 1, 32'h0000_4000, 64'hE0, 2'b10, 0, 0, 0);
    if_valid_i = 1'b1; if_addr_i = 32'h0000_5000;
    run_txn("okay", 0, 32'h0000_5000, 64'hF0, 2'b00, 0, 0, 0);

    // Reset asserted while in R
    if_valid_i = 1'b1; if_addr_i = 32'h0000_6000;
    step();
    axi_ar_ready_i = 1'b1;
    step();
    axi_ar_ready_i = 1'b0;
    chk("midrst.in_r", axi_r_ready_o, 1);
    #2 rst = 1'b0;
    #1 chk_all_zero("midrst");
    if_valid_i = 1'b0;
    exp_if_data = 0; exp_mem_data = 0;
    step();
    rst = 1'b1;
    step();

    // Stray R beat with no request
    axi_r_valid_i = 1'b1; axi_r_id_i = 4'd0; axi_r_data_i = 64'h5555;
    step();
    axi_r_valid_i = 1'b0;
    chk("stray.rr", axi_r_ready_o, 0);
    step();
    chk("stray.rdy", {if_ready_o, mem_ready_o, axi_ar_valid_o}, 0);
    chk("stray.data", if_data_o, 0);

    if_valid_i = 1'b1; if_addr_i = 32'h0000_7000;
    run_txn("post", 0, 32'h0000_7000, 64'h0123_4567_89AB_CDEF, 2'b00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
